// File: rtl/nibble_rle_encoder.sv
// nibble_rle_encoder
// Run-length encoder for a stream of 4-bit samples. Consecutive identical
// nibbles are folded into (value, run-length) pairs. Each pair is presented
// on a registered valid/ready port, and upstream backpressure is exposed
// through in_ready. A run is split when its length reaches the maximum that
// CNT_W bits can hold. A flush closes the open run.

module nibble_rle_encoder #(
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [3:0]       out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             run_active
);

   // Longest run one pair can describe. Also the run length of 1 used to
   // open a fresh run.
   localparam logic [CNT_W-1:0] MAX_RUN  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // IDLE: no run is open. RUN: a run is being accumulated.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_nxt_s;
   logic [3:0]       run_val_r;
   logic [3:0]       run_val_nxt_s;
   logic [CNT_W-1:0] run_cnt_r;
   logic [CNT_W-1:0] run_cnt_nxt_s;

   logic [3:0]       out_data_r;
   logic [CNT_W-1:0] out_count_r;
   logic             out_valid_r;

   logic             slot_free_s;
   logic             in_ready_s;
   logic             accept_s;
   logic             flush_go_s;
   logic             extend_s;
   logic             emit_s;
   logic [3:0]       emit_val_s;
   logic [CNT_W-1:0] emit_cnt_s;

   // Handshake decode. The output slot can take a new pair when it is empty
   // or is being drained this cycle. A pending flush holds off new samples,
   // so a sample and a flush never meet on the same edge.
   always_comb begin
      slot_free_s = (~out_valid_r) | out_ready;
      in_ready_s  = slot_free_s & (~flush);
      accept_s    = in_valid & in_ready_s;
      flush_go_s  = flush & slot_free_s;
      extend_s    = (in_data == run_val_r) && (run_cnt_r != MAX_RUN);
   end

   // Next-state and emit decision for the run accumulator.
   always_comb begin
      state_nxt_s   = state_r;
      run_val_nxt_s = run_val_r;
      run_cnt_nxt_s = run_cnt_r;
      emit_s        = 1'b0;
      emit_val_s    = 4'h0;
      emit_cnt_s    = CNT_ZERO;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_nxt_s   = ST_RUN;
               run_val_nxt_s = in_data;
               run_cnt_nxt_s = CNT_ONE;
            end else begin
               // A flush with no open run has nothing to close.
               state_nxt_s = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (accept_s) begin
               state_nxt_s = ST_RUN;
               if (extend_s) begin
                  run_cnt_nxt_s = run_cnt_r + CNT_ONE;
               end else begin
                  // A different value or a saturated count closes the run.
                  // The incoming sample then opens the next run.
                  emit_s        = 1'b1;
                  emit_val_s    = run_val_r;
                  emit_cnt_s    = run_cnt_r;
                  run_val_nxt_s = in_data;
                  run_cnt_nxt_s = CNT_ONE;
               end
            end else if (flush_go_s) begin
               emit_s        = 1'b1;
               emit_val_s    = run_val_r;
               emit_cnt_s    = run_cnt_r;
               state_nxt_s   = ST_IDLE;
               run_cnt_nxt_s = CNT_ZERO;
            end else begin
               // Idle input cycles are transparent to an open run.
               state_nxt_s = ST_RUN;
            end
         end
         default: begin
            state_nxt_s   = ST_IDLE;
            run_val_nxt_s = 4'h0;
            run_cnt_nxt_s = CNT_ZERO;
         end
      endcase
   end

   // Run accumulator state register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         run_val_r <= 4'h0;
         run_cnt_r <= CNT_ZERO;
      end else begin
         state_r   <= state_nxt_s;
         run_val_r <= run_val_nxt_s;
         run_cnt_r <= run_cnt_nxt_s;
      end
   end

   // Output pair register. An emit loads a new pair, which may replace a pair
   // that is retiring on the same edge. Otherwise an accepted pair clears
   // valid, and a stalled pair is held.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_data_r  <= 4'h0;
         out_count_r <= CNT_ZERO;
      end else if (emit_s) begin
         out_valid_r <= 1'b1;
         out_data_r  <= emit_val_s;
         out_count_r <= emit_cnt_s;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   assign in_ready   = in_ready_s;
   assign out_data   = out_data_r;
   assign out_count  = out_count_r;
   assign out_valid  = out_valid_r;
   assign run_active = (state_r == ST_RUN);

endmodule

// File: tb/tb_nibble_rle_encoder.sv
// Testbench for nibble_rle_encoder. Directed scenarios and random traffic
// drive the design. A reference model predicts each pair and pushes it into
// a queue. A separate monitor pops the queue and compares on every output
// transfer.

module tb_nibble_rle_encoder;

   localparam int CNT_W   = 4;
   localparam int MAX_RUN = 15;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic             flush;
   logic [3:0]       out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_valid;
   logic             out_ready;
   logic             run_active;

   typedef struct packed {
      logic [3:0]       v;
      logic [CNT_W-1:0] n;
   } pair_t;

   pair_t exp_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   // Reference model state: the open run as value plus length (0 = none),
   // and whether the output slot currently holds an unconsumed pair.
   int         m_len = 0;
   logic [3:0] m_val = 4'h0;
   bit         m_occ = 1'b0;
   bit         m_after_rst = 1'b0;

   nibble_rle_encoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .flush      (flush),
      .out_data   (out_data),
      .out_count  (out_count),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .run_active (run_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Reference model. Inputs are stable at the falling edge, so the model
   // decides here what the next rising edge does and predicts the pairs.
   always @(negedge clk) begin
      if (reset) begin
         m_len = 0;
         m_val = 4'h0;
         m_occ = 1'b0;
         exp_q.delete();
         m_after_rst = 1'b1;
      end else begin : model
         bit    sf;
         bit    rdy;
         bit    emit;
         pair_t p;
         check("out_valid", 32'(out_valid), 32'(m_occ));
         check("run_active", 32'(run_active), 32'(m_len != 0));
         if (m_after_rst) begin
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_count", 32'(out_count), 32'd0);
            m_after_rst = 1'b0;
         end
         sf   = !m_occ || out_ready;
         rdy  = sf && !flush;
         check("in_ready", 32'(in_ready), 32'(rdy));
         emit = 1'b0;
         if (in_valid && rdy) begin
            if (m_len == 0) begin
               m_val = in_data;
               m_len = 1;
            end else if (in_data == m_val && m_len < MAX_RUN) begin
               m_len++;
            end else begin
               p.v = m_val;
               p.n = m_len[CNT_W-1:0];
               exp_q.push_back(p);
               emit  = 1'b1;
               m_val = in_data;
               m_len = 1;
            end
         end else if (flush && sf && m_len > 0) begin
            p.v = m_val;
            p.n = m_len[CNT_W-1:0];
            exp_q.push_back(p);
            emit  = 1'b1;
            m_len = 0;
         end
         m_occ = emit ? 1'b1 : (out_ready ? 1'b0 : m_occ);
      end
   end

   // Scoreboard monitor: every accepted output pair is popped and compared.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin : mon
         pair_t e;
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pair: got (%0h,%0d), expected no pair", out_data, out_count);
         end else begin
            e = exp_q.pop_front();
            check("pair", 32'({out_data, out_count}), 32'({e.v, e.n}));
         end
      end
   end

   task automatic cyc(input bit v, input logic [3:0] d, input bit f, input bit r, input bit rst);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_data   = d;
      flush     = f;
      out_ready = r;
      reset     = rst;
   endtask

   task automatic feed(input logic [3:0] d, input bit r);
      cyc(1'b1, d, 1'b0, r, 1'b0);
   endtask

   task automatic idle(input int n, input bit f, input bit r);
      for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, f, r, 1'b0);
   endtask

   initial begin : stim
      logic [3:0] d;
      bit         v;
      bit         f;
      bit         r;
      bit         rs;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      flush     = 1'b0;
      out_ready = 1'b0;

      // Basic runs: 7,F,F,F,8,B,B then flush.
      cyc(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
      feed(4'h7, 1'b1); feed(4'hF, 1'b1); feed(4'hF, 1'b1); feed(4'hF, 1'b1);
      feed(4'h8, 1'b1); feed(4'hB, 1'b1); feed(4'hB, 1'b1);
      idle(1, 1'b1, 1'b1);
      idle(2, 1'b0, 1'b1);

      // Saturation: 17 x A then 3.
      for (int i = 0; i < 17; i++) feed(4'hA, 1'b1);
      feed(4'h3, 1'b1);
      idle(1, 1'b1, 1'b1);
      idle(2, 1'b0, 1'b1);

      // Backpressure: 1,2,3 with out_ready low. The flush then closes run 2
      // on the same edge that (1,1) retires.
      feed(4'h1, 1'b0); feed(4'h2, 1'b0); feed(4'h3, 1'b0); feed(4'h3, 1'b0);
      idle(1, 1'b1, 1'b1);
      idle(2, 1'b0, 1'b1);

      // Gaps are transparent, then a flush with no run does nothing.
      feed(4'h5, 1'b1);
      idle(3, 1'b0, 1'b1);
      feed(4'h5, 1'b1);
      idle(1, 1'b1, 1'b1);
      idle(2, 1'b0, 1'b1);
      idle(1, 1'b1, 1'b1);
      idle(2, 1'b0, 1'b1);

      // Flush blocked by a stalled output, then honoured.
      feed(4'h6, 1'b0); feed(4'h9, 1'b0);
      idle(2, 1'b1, 1'b0);
      idle(1, 1'b1, 1'b1);
      idle(2, 1'b0, 1'b1);

      // Reset mid-operation with a pending pair and an open run.
      feed(4'h9, 1'b0); feed(4'hC, 1'b0); feed(4'hC, 1'b0);
      cyc(1'b1, 4'hC, 1'b1, 1'b0, 1'b1);
      feed(4'h4, 1'b1);
      idle(1, 1'b1, 1'b1);
      idle(2, 1'b0, 1'b1);

      // Random traffic with sticky data so that long runs also occur.
      d = 4'h0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0) d = 4'($urandom_range(0, 15));
         v  = ($urandom_range(0, 3) != 0);
         f  = ($urandom_range(0, 11) == 0);
         r  = ($urandom_range(0, 3) != 0);
         rs = ($urandom_range(0, 299) == 0);
         cyc(v, d, f, r, rs);
      end

      // Close any open run and drain the output.
      idle(1, 1'b0, 1'b1);
      idle(1, 1'b1, 1'b1);
      idle(4, 1'b0, 1'b1);
      @(negedge clk);
      check("drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
